// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing defaults, checksum width, receiver state encoding.
// Usable by both the vga_sync source and the vga_frame_receiver sink.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int SUM_W        = 16;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

   // Per-pixel checksum contribution, zero-extended to the checksum width.
   function automatic logic [SUM_W-1:0] pixel_hash(input logic [9:0] r,
                                                   input logic [9:0] g,
                                                   input logic [9:0] b);
      return {{(SUM_W-10){1'b0}}, r ^ g ^ b};
   endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Two-flop sampler with rise/fall pulses for a group of single-bit sync/blank signals.
// The pulses are aligned with the first-stage sample q.
module vga_edge_det #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] q,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] d1, d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         d1 <= '0;
         d2 <= '0;
      end else begin
         d1 <= din;
         d2 <= d1;
      end
   end

   assign q    = d1;
   assign rise = d1 & ~d2;
   assign fall = d2 & ~d1;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA sink: recovers pixel coordinates, measures active geometry, declares lock
// and produces a per-frame checksum of the received pixels.
module vga_frame_receiver
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int LOCK_FRAMES = 2,
   parameter int CW          = 10
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iVGA_H_SYNC,
   input  logic             iVGA_V_SYNC,
   input  logic             iVGA_BLANK,
   input  logic [9:0]       iRed,
   input  logic [9:0]       iGreen,
   input  logic [9:0]       iBlue,
   output logic [CW-1:0]    oPx,
   output logic [CW-1:0]    oPy,
   output logic             oPixel_valid,
   output logic [29:0]      oPixel,
   output logic             oFrame_start,
   output logic [SUM_W-1:0] oFrame_sum,
   output logic [CW-1:0]    oLine_len,
   output logic [CW-1:0]    oFrame_lines,
   output logic             oLocked,
   output logic [7:0]       oErr_count,
   output rx_state_t        oState
);

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] H_LEN   = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_LEN   = CW'(V_ACTIVE);

   // Bit order: 0 = HS, 1 = VS, 2 = BLANK.
   logic [2:0] sync_q, sync_rise, sync_fall;
   logic [4:0] unused_sync;

   vga_edge_det #(.W(3)) u_edge (
      .clk  (iCLK),
      .rst  (iRST),
      .din  ({iVGA_BLANK, iVGA_V_SYNC, iVGA_H_SYNC}),
      .q    (sync_q),
      .rise (sync_rise),
      .fall (sync_fall)
   );

   assign unused_sync = {sync_q[1:0], sync_rise};

   logic [29:0]      data_q;
   logic [CW-1:0]    x_cnt_q, y_cnt_q;
   logic [SUM_W-1:0] sum_q;
   logic             bad_q;
   logic [7:0]       good_cnt_q, good_cnt_d;
   rx_state_t        state_q, state_d;
   logic             err_inc;

   logic             hs_fall, vs_fall, blank_fall, active, tracking;
   logic             line_close, line_bad, y_sat, frame_bad, frame_good, pix_en, x_sat;
   logic [CW-1:0]    y_closed, x_base, y_base;
   logic [SUM_W-1:0] sum_base;
   logic             bad_base;

   assign hs_fall    = sync_fall[0];
   assign vs_fall    = sync_fall[1];
   assign blank_fall = sync_fall[2];
   assign active     = sync_q[2];
   assign tracking   = (state_q != ST_SEARCH);

   // A line closing in the VS-fall cycle still belongs to the ending frame,
   // and a pixel in that cycle is the first of the new frame.
   assign line_close = tracking && blank_fall;
   assign line_bad   = line_close && (x_cnt_q != H_LEN);
   assign y_sat      = line_close && (y_cnt_q == CNT_MAX);
   assign y_closed   = (line_close && !y_sat) ? y_cnt_q + 1'b1 : y_cnt_q;
   assign frame_bad  = bad_q || line_bad || y_sat;
   assign frame_good = !frame_bad && (y_closed == V_LEN);

   assign pix_en   = active && (tracking || vs_fall);
   assign x_base   = (hs_fall || blank_fall) ? '0 : x_cnt_q;
   assign y_base   = vs_fall ? '0 : y_closed;
   assign sum_base = vs_fall ? '0 : sum_q;
   assign bad_base = vs_fall ? 1'b0 : frame_bad;
   assign x_sat    = pix_en && (x_base == CNT_MAX);

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      err_inc    = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (vs_fall) begin
               state_d    = ST_MEASURE;
               good_cnt_d = '0;
            end
         end
         ST_MEASURE: begin
            if (vs_fall) begin
               if (!frame_good) begin
                  good_cnt_d = '0;
               end else if (int'(good_cnt_q) + 1 >= LOCK_FRAMES) begin
                  state_d    = ST_LOCKED;
                  good_cnt_d = '0;
               end else begin
                  good_cnt_d = good_cnt_q + 8'd1;
               end
            end
         end
         ST_LOCKED: begin
            if (vs_fall && !frame_good) begin
               state_d    = ST_MEASURE;
               good_cnt_d = '0;
               err_inc    = 1'b1;
            end
         end
         default: state_d = ST_SEARCH;
      endcase
   end

   // oPixel_valid qualifies oPx/oPy/oPixel for exactly one cycle; there is no backpressure.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q      <= ST_SEARCH;
         good_cnt_q   <= '0;
         data_q       <= '0;
         x_cnt_q      <= '0;
         y_cnt_q      <= '0;
         sum_q        <= '0;
         bad_q        <= 1'b0;
         oPx          <= '0;
         oPy          <= '0;
         oPixel_valid <= 1'b0;
         oPixel       <= '0;
         oFrame_start <= 1'b0;
         oFrame_sum   <= '0;
         oLine_len    <= '0;
         oFrame_lines <= '0;
         oLocked      <= 1'b0;
         oErr_count   <= '0;
      end else begin
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         data_q       <= {iRed, iGreen, iBlue};
         x_cnt_q      <= (pix_en && !x_sat) ? x_base + 1'b1 : x_base;
         y_cnt_q      <= y_base;
         sum_q        <= pix_en ? sum_base + pixel_hash(data_q[29:20], data_q[19:10], data_q[9:0])
                                : sum_base;
         bad_q        <= bad_base || x_sat;
         oFrame_start <= vs_fall;
         oPixel_valid <= pix_en;
         oLocked      <= (state_d == ST_LOCKED);
         if (pix_en) begin
            oPx    <= x_base;
            oPy    <= y_base;
            oPixel <= data_q;
         end
         if (line_close)
            oLine_len <= x_cnt_q;
         if (tracking && vs_fall) begin
            oFrame_lines <= y_closed;
            oFrame_sum   <= sum_q;
         end
         if (err_inc && oErr_count != 8'hFF)
            oErr_count <= oErr_count + 8'd1;
      end
   end

   assign oState = state_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver using a reduced 16x12 active geometry
// (24-cycle lines, 16-line frames) so every scenario fits in a short run.
module tb_vga_frame_receiver;
   import vga_pkg::*;

   localparam int HA = 16;
   localparam int VA = 12;
   localparam int HBLANK = 8;
   localparam logic [29:0] PIX  = {10'h155, 10'h155, 10'h155};
   localparam logic [29:0] MARK = {10'h3FF, 10'h00F, 10'h0F0};

   logic             clk = 1'b0;
   logic             rst;
   logic             hs, vs, blank;
   logic [9:0]       red, green, blue;
   logic [9:0]       px, py;
   logic             pix_valid;
   logic [29:0]      pixel;
   logic             frame_start;
   logic [15:0]      frame_sum;
   logic [9:0]       line_len, frame_lines;
   logic             locked;
   logic [7:0]       err_count;
   rx_state_t        state;

   int vec = 0;
   int err = 0;
   int cyc = 0;

   // Values captured at each oFrame_start pulse.
   int          fs_count = 0;
   logic [9:0]  snap_lines, snap_len;
   logic [15:0] snap_sum;
   logic        snap_locked;
   logic [7:0]  snap_err;

   logic        watch = 1'b0;
   int          pv_count = 0;
   logic        mark_seen = 1'b0;
   int          mark_cyc = 0, seen_cyc = 0;
   logic [9:0]  seen_px, seen_py;
   logic [29:0] seen_pix;

   vga_frame_receiver #(.H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .CW(10)) dut (
      .iCLK         (clk),
      .iRST         (rst),
      .iVGA_H_SYNC  (hs),
      .iVGA_V_SYNC  (vs),
      .iVGA_BLANK   (blank),
      .iRed         (red),
      .iGreen       (green),
      .iBlue        (blue),
      .oPx          (px),
      .oPy          (py),
      .oPixel_valid (pix_valid),
      .oPixel       (pixel),
      .oFrame_start (frame_start),
      .oFrame_sum   (frame_sum),
      .oLine_len    (line_len),
      .oFrame_lines (frame_lines),
      .oLocked      (locked),
      .oErr_count   (err_count),
      .oState       (state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, %0d frames seen", fs_count);
      $fatal(1);
   end

   always @(negedge clk) begin
      if (frame_start === 1'b1) begin
         fs_count++;
         snap_lines  = frame_lines;
         snap_len    = line_len;
         snap_sum    = frame_sum;
         snap_locked = locked;
         snap_err    = err_count;
      end
      if (watch && pix_valid === 1'b1) pv_count++;
      if (!mark_seen && pix_valid === 1'b1 && pixel === MARK) begin
         mark_seen = 1'b1;
         seen_cyc  = cyc;
         seen_px   = px;
         seen_py   = py;
         seen_pix  = pixel;
      end
   end

   // driver tasks
   task automatic put(input logic h, input logic v, input logic b, input logic [29:0] d);
      hs = h; vs = v; blank = b;
      {red, green, blue} = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_line(input int act, input logic v, input logic [29:0] d,
                             input int mark_x);
      for (int i = 0; i < act; i++) begin
         if (i == mark_x) begin
            mark_cyc = cyc;
            put(1'b1, v, 1'b1, MARK);
         end else begin
            put(1'b1, v, 1'b1, d);
         end
      end
      for (int i = 0; i < HBLANK; i++) put(!(i >= 2 && i < 5), v, 1'b0, 30'd0);
   endtask

   task automatic drive_blank_line(input logic v);
      for (int i = 0; i < HA + HBLANK; i++) put(!(i >= 2 && i < 5), v, 1'b0, 30'd0);
   endtask

   task automatic drive_vblank();
      drive_blank_line(1'b1);
      drive_blank_line(1'b0);
      drive_blank_line(1'b0);
      drive_blank_line(1'b1);
   endtask

   task automatic send_frame(input int n_lines, input int odd_line, input int odd_len,
                             input logic [29:0] d, input int mark_y, input int mark_x);
      for (int l = 0; l < n_lines; l++)
         drive_line((l == odd_line) ? odd_len : HA, 1'b1, d, (l == mark_y) ? mark_x : -1);
      drive_vblank();
   endtask

   // scenarios
   task automatic test_reset();
      rst = 1'b1;
      put(1'b1, 1'b1, 1'b0, 30'd0);
      put(1'b1, 1'b1, 1'b0, 30'd0);
      vec++; if (px !== 10'd0) begin err++; $display("FAIL reset_px: got %0d want 0", px); end
      vec++; if (py !== 10'd0) begin err++; $display("FAIL reset_py: got %0d want 0", py); end
      vec++; if (pix_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", pix_valid); end
      vec++; if (pixel !== 30'd0) begin err++; $display("FAIL reset_pixel: got %h want 0", pixel); end
      vec++; if (frame_start !== 1'b0) begin err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
      vec++; if (frame_sum !== 16'd0) begin err++; $display("FAIL reset_sum: got %h want 0", frame_sum); end
      vec++; if (line_len !== 10'd0) begin err++; $display("FAIL reset_len: got %0d want 0", line_len); end
      vec++; if (frame_lines !== 10'd0) begin err++; $display("FAIL reset_lines: got %0d want 0", frame_lines); end
      vec++; if (locked !== 1'b0) begin err++; $display("FAIL reset_locked: got %b want 0", locked); end
      vec++; if (err_count !== 8'd0) begin err++; $display("FAIL reset_err: got %0d want 0", err_count); end
      vec++; if (state !== ST_SEARCH) begin err++; $display("FAIL reset_state: got %0d want %0d", state, ST_SEARCH); end
      rst = 1'b0;
   endtask

   task automatic test_lock();
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (fs_count !== 1) begin err++; $display("FAIL lock_f0_fs: got %0d want 1", fs_count); end
      vec++; if (snap_lines !== 10'd0) begin err++; $display("FAIL lock_f0_unevaluated: lines %0d want 0", snap_lines); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_lines !== 10'd12) begin err++; $display("FAIL lock_f1_lines: got %0d want 12", snap_lines); end
      vec++; if (snap_len !== 10'd16) begin err++; $display("FAIL lock_f1_len: got %0d want 16", snap_len); end
      vec++; if (snap_sum !== 16'hFFC0) begin err++; $display("FAIL lock_f1_sum: got %h want ffc0", snap_sum); end
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL lock_f1_locked: got %b want 0", snap_locked); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b1) begin err++; $display("FAIL lock_f2_locked: got %b want 1", snap_locked); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b1) begin err++; $display("FAIL lock_f3_locked: got %b want 1", snap_locked); end
      vec++; if (snap_sum !== 16'hFFC0) begin err++; $display("FAIL lock_f3_sum: got %h want ffc0", snap_sum); end
      vec++; if (fs_count !== 4) begin err++; $display("FAIL lock_fs_count: got %0d want 4", fs_count); end
   endtask

   task automatic test_bad_line();
      send_frame(VA, 5, HA - 1, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL bad_locked: got %b want 0", snap_locked); end
      vec++; if (snap_err !== 8'd1) begin err++; $display("FAIL bad_err: got %0d want 1", snap_err); end
      vec++; if (snap_len !== 10'd16) begin err++; $display("FAIL bad_last_len: got %0d want 16", snap_len); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL relock_g1: got %b want 0", snap_locked); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b1) begin err++; $display("FAIL relock_g2: got %b want 1", snap_locked); end
      vec++; if (snap_err !== 8'd1) begin err++; $display("FAIL relock_err: got %0d want 1", snap_err); end
   endtask

   task automatic test_marker();
      mark_seen = 1'b0;
      send_frame(VA, -1, 0, 30'd0, 7, 5);
      vec++; if (mark_seen !== 1'b1) begin err++; $display("FAIL marker_seen: got %b want 1", mark_seen); end
      vec++; if (seen_cyc - mark_cyc !== 2) begin err++; $display("FAIL marker_latency: got %0d want 2", seen_cyc - mark_cyc); end
      vec++; if (seen_px !== 10'd5) begin err++; $display("FAIL marker_px: got %0d want 5", seen_px); end
      vec++; if (seen_py !== 10'd7) begin err++; $display("FAIL marker_py: got %0d want 7", seen_py); end
      vec++; if (seen_pix !== MARK) begin err++; $display("FAIL marker_pixel: got %h want %h", seen_pix, MARK); end
      vec++; if (snap_sum !== 16'h0300) begin err++; $display("FAIL marker_sum: got %h want 0300", snap_sum); end
      vec++; if (snap_locked !== 1'b1) begin err++; $display("FAIL marker_locked: got %b want 1", snap_locked); end
   endtask

   task automatic test_mid_reset();
      int fs_before;
      for (int l = 0; l < 6; l++) drive_line(HA, 1'b1, PIX, -1);
      for (int i = 0; i < 3; i++) put(1'b1, 1'b1, 1'b1, PIX);
      rst = 1'b1;
      put(1'b1, 1'b1, 1'b1, PIX);
      vec++; if (pix_valid !== 1'b0 || locked !== 1'b0 || frame_sum !== 16'd0 || frame_lines !== 10'd0 ||
                 line_len !== 10'd0 || err_count !== 8'd0 || px !== 10'd0 || py !== 10'd0 || pixel !== 30'd0 ||
                 frame_start !== 1'b0) begin
         err++;
         $display("FAIL midrst_outputs: valid=%b locked=%b sum=%h lines=%0d len=%0d errc=%0d px=%0d py=%0d pix=%h fs=%b want all 0",
                  pix_valid, locked, frame_sum, frame_lines, line_len, err_count, px, py, pixel, frame_start);
      end
      rst = 1'b0;
      fs_before = fs_count;
      watch = 1'b1;
      pv_count = 0;
      for (int i = 4; i < HA; i++) put(1'b1, 1'b1, 1'b1, PIX);
      for (int i = 0; i < HBLANK; i++) put(!(i >= 2 && i < 5), 1'b1, 1'b0, 30'd0);
      for (int l = 7; l < VA; l++) drive_line(HA, 1'b1, PIX, -1);
      vec++; if (fs_count !== fs_before) begin err++; $display("FAIL midrst_no_fs: got %0d want %0d", fs_count, fs_before); end
      vec++; if (line_len !== 10'd0) begin err++; $display("FAIL midrst_len_ignored: got %0d want 0", line_len); end
      drive_vblank();
      watch = 1'b0;
      vec++; if (pv_count !== 0) begin err++; $display("FAIL midrst_search_valid: got %0d want 0", pv_count); end
      vec++; if (fs_count !== fs_before + 1) begin err++; $display("FAIL midrst_fs: got %0d want %0d", fs_count, fs_before + 1); end
      vec++; if (snap_lines !== 10'd0) begin err++; $display("FAIL midrst_unevaluated: lines %0d want 0", snap_lines); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL midrst_g1: got %b want 0", snap_locked); end
      vec++; if (snap_lines !== 10'd12) begin err++; $display("FAIL midrst_g1_lines: got %0d want 12", snap_lines); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b1) begin err++; $display("FAIL midrst_g2: got %b want 1", snap_locked); end
   endtask

   task automatic test_bad_geometry();
      send_frame(VA + 1, -1, 0, PIX, -1, -1);
      vec++; if (snap_lines !== 10'd13) begin err++; $display("FAIL tall_lines: got %0d want 13", snap_lines); end
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL tall_locked: got %b want 0", snap_locked); end
      vec++; if (snap_err !== 8'd1) begin err++; $display("FAIL tall_err: got %0d want 1", snap_err); end
      for (int l = 0; l < VA; l++) begin
         drive_line((l == 3) ? 1100 : HA, 1'b1, PIX, -1);
         if (l == 3) begin
            vec++; if (line_len !== 10'd1023) begin err++; $display("FAIL long_sat_len: got %0d want 1023", line_len); end
         end
      end
      drive_vblank();
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL long_locked: got %b want 0", snap_locked); end
      vec++; if (snap_err !== 8'd1) begin err++; $display("FAIL long_err: got %0d want 1", snap_err); end
      send_frame(VA, -1, 0, PIX, -1, -1);
      vec++; if (snap_locked !== 1'b0) begin err++; $display("FAIL after_bad_g1: got %b want 0", snap_locked); end
      vec++; if (state !== ST_MEASURE) begin err++; $display("FAIL after_bad_state: got %0d want %0d", state, ST_MEASURE); end
   endtask

   initial begin
      rst = 1'b1;
      hs = 1'b1; vs = 1'b1; blank = 1'b0;
      red = '0; green = '0; blue = '0;
      test_reset();
      test_lock();
      test_bad_line();
      test_marker();
      test_mid_reset();
      test_bad_geometry();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
